// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: hold PLL in reset, wait for stable lock with timeout/retry, then release domains.
// Latency: 2-cycle lock synchronizer plus 1 state register; outputs are flops updated with the state.
// Backpressure: none, free-running in refclk; PLL_SEQ_STATUS_EN builds the lock-loss counter.
`timescale 1ns/1ps
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int MAX_RETRY           = 3,
    parameter int CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       user_rst_req,
    output logic       pll_rst,
    output logic       clk_ready,
    output logic       domain_rst_n,
    output logic       fault,
    output logic [7:0] lock_lost_cnt
);

    typedef enum logic [4:0] {
        ST_RESET_HOLD = 5'b00001,
        ST_WAIT_LOCK  = 5'b00010,
        ST_STABLE     = 5'b00100,
        ST_RUN        = 5'b01000,
        ST_FAULT      = 5'b10000
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRY);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       retry, retry_nxt, retry_inc;
    logic             lock_m, lock_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        retry_nxt = retry;
        retry_inc = retry + 8'd1;
        if (user_rst_req) begin
            // Software restart overrides whatever the FSM would otherwise do this cycle
            state_nxt = ST_RESET_HOLD;
            cnt_nxt   = '0;
            retry_nxt = 8'd0;
        end else begin
            case (state)
                ST_RESET_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt_nxt   = '0;
                        retry_nxt = retry_inc;
                        state_nxt = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_RESET_HOLD;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_nxt = '0;
                    if (!lock_s) begin
                        state_nxt = ST_RESET_HOLD;
                        retry_nxt = 8'd0;
                    end
                end
                ST_FAULT: cnt_nxt = '0;
                default: begin
                    state_nxt = ST_RESET_HOLD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state register
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RESET_HOLD;
            cnt          <= '0;
            retry        <= 8'd0;
            pll_rst      <= 1'b1;
            clk_ready    <= 1'b0;
            domain_rst_n <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            retry        <= retry_nxt;
            pll_rst      <= (state_nxt == ST_RESET_HOLD) || (state_nxt == ST_FAULT);
            clk_ready    <= (state_nxt == ST_RUN);
            domain_rst_n <= (state_nxt == ST_RUN);
            fault        <= (state_nxt == ST_FAULT);
        end
    end

`ifdef PLL_SEQ_STATUS_EN
    logic run_loss;
    assign run_loss = (state == ST_RUN) && !lock_s && !user_rst_req;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost_cnt <= 8'd0;
        end else if (run_loss && (lock_lost_cnt != 8'hFF)) begin
            lock_lost_cnt <= lock_lost_cnt + 8'd1;
        end
    end
`else
    assign lock_lost_cnt = 8'h00;
`endif

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock sequencer for the HPS memory PLL (50 MHz reference, 100/200 MHz outputs). It holds the PLL in reset after power-up, waits for a stable lock with timeout and bounded retries, and only then releases the downstream clock-domain reset. It re-sequences the PLL on loss of lock or on a software request. It sits between the board reset and the PLL wrapper, in the `refclk` domain.

## Interface
- `RST_HOLD_CYCLES`, 16: cycles `pll_rst` is held high per attempt; ≥1.
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles allowed in WAIT_LOCK before the attempt fails; ≥2.
- `LOCK_STABLE_CYCLES`, 256: consecutive synchronized-lock cycles required before release; ≥1.
- `MAX_RETRY`, 3: failed attempts before FAULT; 1..255.
- `CNT_W`, 20: shared cycle-counter width; must hold max(all cycle parameters).

Ports:
- `refclk` in 1: 50 MHz reference clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL `locked`; asynchronous; synchronized internally.
- `user_rst_req` in 1: single-cycle request to restart sequencing.
- `pll_rst` out 1: active-high PLL reset.
- `clk_ready` out 1: PLL outputs are valid.
- `domain_rst_n` out 1: active-low release for downstream domains. Each consumer re-synchronizes it.
- `fault` out 1: retries exhausted.
- `lock_lost_cnt` out 8: saturating count of lock losses while in RUN.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`.
- One-hot FSM: RESET_HOLD, WAIT_LOCK, STABLE, RUN, FAULT. It has one `CNT_W` counter and a `retry` counter (8 bits).
- Outputs are flops decoded from the registered state:
  - `pll_rst` = RESET_HOLD | FAULT.
  - `clk_ready` = `domain_rst_n` = RUN.
  - `fault` = FAULT.
- RESET_HOLD:
  - The counter increments each cycle.
  - At `RST_HOLD_CYCLES`−1 the FSM moves to WAIT_LOCK and clears the counter.
- WAIT_LOCK:
  - If `lock_s`=1, the FSM moves to STABLE and clears the counter.
  - Otherwise, at `LOCK_TIMEOUT_CYCLES`−1, `retry`+1 is evaluated. If it equals `MAX_RETRY`, the FSM moves to FAULT; otherwise to RESET_HOLD.
- STABLE:
  - If `lock_s`=0, the FSM returns to WAIT_LOCK and clears the counter. `retry` is unchanged.
  - After `LOCK_STABLE_CYCLES` consecutive cycles with `lock_s`=1, the FSM moves to RUN.
- RUN:
  - If `lock_s`=0, the FSM moves to RESET_HOLD, clears `retry`, and increments `lock_lost_cnt`. The counter saturates at 255.
- FAULT: absorbing. It exits only via `user_rst_req` or `rst_n`.
- `user_rst_req`=1 in any state:
  - The next state is RESET_HOLD; the counter and `retry` are cleared.
  - It has priority over every other transition in the same cycle.
  - `lock_lost_cnt` is not cleared.
  - A request while already in RESET_HOLD restarts the hold count.
- Reset values (`rst_n`=0):
  - State RESET_HOLD; counter 0; `retry` 0; synchronizer flops 0.
  - Outputs: `pll_rst`=1, `clk_ready`=0, `domain_rst_n`=0, `fault`=0, `lock_lost_cnt`=0.
- Reset mid-operation returns immediately and asynchronously to these values.

## Timing
- Synchronizer latency is 2 cycles from a `pll_locked` edge to `lock_s`.
- After `rst_n` deasserts, `pll_rst` stays high for exactly `RST_HOLD_CYCLES` rising edges, then drops.
- Minimum time from `pll_rst` falling to `clk_ready` rising is 2 + `LOCK_STABLE_CYCLES` + 1 cycles, with `pll_locked` high immediately.
- In RUN, a `pll_locked` fall gives `clk_ready`/`domain_rst_n` low and `pll_rst` high 3 cycles later (2 synchronizer cycles + 1 state register).
- `user_rst_req` takes effect on outputs 1 cycle after it is sampled.
- Lock glitches shorter than one `refclk` period may be missed. This is accepted.

## Configuration
- `PLL_SEQ_STATUS_EN` defined: the `lock_lost_cnt` saturating counter is built as specified.
- `PLL_SEQ_STATUS_EN` undefined:
  - `lock_lost_cnt` is tied to 8'h00 and no counter logic is built.
  - All FSM, retry and fault behaviour is identical.

## Test plan
All scenarios use `RST_HOLD_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=20, `LOCK_STABLE_CYCLES`=8, `MAX_RETRY`=2.
- Nominal bring-up:
  - Stimulus: release `rst_n`; raise `pll_locked` 5 cycles after `pll_rst` falls.
  - Required: `pll_rst` high for 4 cycles; `clk_ready`=`domain_rst_n`=1 exactly 2+8+1 cycles after lock rises; `fault`=0.
- Unstable lock:
  - Stimulus: `pll_locked` high 5 cycles, low 1 cycle, then high.
  - Required: STABLE re-entered via WAIT_LOCK; `clk_ready` rises 11 cycles after the final rise; `pll_rst` never reasserts.
- Timeout and fault:
  - Stimulus: `pll_locked` held 0.
  - Required: two 4-cycle `pll_rst` pulses separated by 20 cycles low; then `pll_rst`=1 and `fault`=1 permanently.
- Lock loss in RUN:
  - Stimulus: drop `pll_locked` once in RUN.
  - Required: 3 cycles later `clk_ready`=0 and `pll_rst`=1; `lock_lost_cnt`=1; full re-sequence follows. Repeat 256 losses: the count stays at 255.
- Software restart:
  - Stimulus: pulse `user_rst_req` in FAULT; separately, pulse it in STABLE coincident with the completing stable count.
  - Required: in both cases RESET_HOLD next cycle; `fault`=0; `lock_lost_cnt` unchanged; `clk_ready` stays 0.
- Macro off:
  - Stimulus: repeat the lock-loss scenario with `PLL_SEQ_STATUS_EN` undefined.
  - Required: identical FSM traces; `lock_lost_cnt`=0 throughout.
